// File: rtl/axi_sram_slave.sv
// AXI4 slave serving INCR bursts from a word-addressed on-chip memory array.
// One transaction at a time; every beat is 4 bytes. Writes take priority over
// reads when both address channels are offered in the same idle cycle.
module axi_sram_slave #(
    parameter int ID_W  = 8,
    parameter int LEN_W = 4,
    parameter int DEPTH = 16384
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ID_W-1:0]  ARID_S,
    input  logic [31:0]      ARADDR_S,
    input  logic [LEN_W-1:0] ARLEN_S,
    input  logic             ARVALID_S,
    output logic             ARREADY_S,
    output logic [ID_W-1:0]  RID_S,
    output logic [31:0]      RDATA_S,
    output logic [1:0]       RRESP_S,
    output logic             RLAST_S,
    output logic             RVALID_S,
    input  logic             RREADY_S,
    input  logic [ID_W-1:0]  AWID_S,
    input  logic [31:0]      AWADDR_S,
    input  logic [LEN_W-1:0] AWLEN_S,
    input  logic             AWVALID_S,
    output logic             AWREADY_S,
    input  logic [31:0]      WDATA_S,
    input  logic [3:0]       WSTRB_S,
    input  logic             WLAST_S,
    input  logic             WVALID_S,
    output logic             WREADY_S,
    output logic [ID_W-1:0]  BID_S,
    output logic [1:0]       BRESP_S,
    output logic             BVALID_S,
    input  logic             BREADY_S
);

    localparam int          IDX_W       = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_WORDS = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t           state;
    logic             idle_rdy;
    logic [29:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             err_q;
    logic             dec_q;
    logic [31:0]      mem [DEPTH];

    logic [29:0]      addr_inc;
    logic [LEN_W-1:0] cnt_inc;
    logic             ar_fire;
    logic             aw_fire;
    logic             r_fire;
    logic             w_fire;
    logic             b_fire;
    logic             beat_err;
    logic             beat_dec;
    logic             unused_addr_bits;

    // Word index is in range when it falls below the array depth.
    function automatic logic in_range(input logic [29:0] w);
        return {2'b00, w} < DEPTH_WORDS;
    endfunction

    // Out-of-range words read back as zero.
    function automatic logic [31:0] read_word(input logic [29:0] w);
        return in_range(w) ? mem[w[IDX_W-1:0]] : 32'h0;
    endfunction

    // The address channels are only offered once the FSM has settled in IDLE,
    // and a pending write hides the read channel.
    assign AWREADY_S = idle_rdy;
    assign ARREADY_S = idle_rdy && !AWVALID_S;

    assign ar_fire  = ARVALID_S && ARREADY_S;
    assign aw_fire  = AWVALID_S && AWREADY_S;
    assign r_fire   = RVALID_S && RREADY_S;
    assign w_fire   = WVALID_S && WREADY_S;
    assign b_fire   = BVALID_S && BREADY_S;
    assign addr_inc = addr_q + 30'd1;
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign beat_err = WLAST_S != (cnt_q == len_q);
    assign beat_dec = !in_range(addr_q);

    assign unused_addr_bits = ^{ARADDR_S[1:0], AWADDR_S[1:0]};

    // Byte-masked write port; reset blocks a write that coincides with it.
    always_ff @(posedge clk) begin
        if (rst && w_fire && in_range(addr_q)) begin
            for (int i = 0; i < 4; i++) begin
                if (WSTRB_S[i]) begin
                    mem[addr_q[IDX_W-1:0]][8*i +: 8] <= WDATA_S[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with all channel outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idle_rdy <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            dec_q    <= 1'b0;
            RID_S    <= '0;
            RDATA_S  <= '0;
            RRESP_S  <= 2'b00;
            RLAST_S  <= 1'b0;
            RVALID_S <= 1'b0;
            WREADY_S <= 1'b0;
            BID_S    <= '0;
            BRESP_S  <= 2'b00;
            BVALID_S <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idle_rdy <= 1'b1;
                    if (aw_fire) begin
                        state    <= WR;
                        idle_rdy <= 1'b0;
                        BID_S    <= AWID_S;
                        addr_q   <= AWADDR_S[31:2];
                        len_q    <= AWLEN_S;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        dec_q    <= 1'b0;
                        WREADY_S <= 1'b1;
                    end else if (ar_fire) begin
                        state    <= RD;
                        idle_rdy <= 1'b0;
                        RID_S    <= ARID_S;
                        addr_q   <= ARADDR_S[31:2];
                        len_q    <= ARLEN_S;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        RVALID_S <= 1'b1;
                        RDATA_S  <= read_word(ARADDR_S[31:2]);
                        RRESP_S  <= in_range(ARADDR_S[31:2]) ? 2'b00 : 2'b11;
                        RLAST_S  <= (ARLEN_S == '0);
                    end
                end
                RD: begin
                    if (r_fire) begin
                        if (RLAST_S) begin
                            state    <= IDLE;
                            idle_rdy <= 1'b1;
                            RVALID_S <= 1'b0;
                            RLAST_S  <= 1'b0;
                            RDATA_S  <= '0;
                            RRESP_S  <= 2'b00;
                        end else begin
                            addr_q  <= addr_inc;
                            cnt_q   <= cnt_inc;
                            RDATA_S <= read_word(addr_inc);
                            RRESP_S <= in_range(addr_inc) ? 2'b00 : 2'b11;
                            RLAST_S <= (cnt_inc == len_q);
                        end
                    end
                end
                WR: begin
                    if (w_fire) begin
                        addr_q <= addr_inc;
                        cnt_q  <= cnt_inc;
                        err_q  <= err_q | beat_err;
                        dec_q  <= dec_q | beat_dec;
                        if (WLAST_S) begin
                            state    <= WRESP;
                            WREADY_S <= 1'b0;
                            BVALID_S <= 1'b1;
                            BRESP_S  <= (dec_q | beat_dec) ? 2'b11 :
                                        (err_q | beat_err) ? 2'b10 : 2'b00;
                        end
                    end
                end
                WRESP: begin
                    if (b_fire) begin
                        state    <= IDLE;
                        idle_rdy <= 1'b1;
                        BVALID_S <= 1'b0;
                        BRESP_S  <= 2'b00;
                    end
                end
                default: begin
                    state    <= IDLE;
                    idle_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule
